// File: rtl/question_issuer_if.sv
// question_issuer_if -- handshake bundle between the question issuer, the OBC
// under test and the downstream answer checker.
//   slave  : the issuer side (drives questions, pairs and status)
//   master : the environment side (drives enable and the OBC answer)
interface question_issuer_if;
   logic       enable;
   logic [3:0] question;
   logic       q_valid;
   logic [3:0] answerOBC;
   logic       a_valid;
   logic       pair_valid;
   logic [3:0] pair_question;
   logic [3:0] pair_answer;
   logic       timeout;
   logic       busy;
   logic [7:0] txn_count;

   modport slave (
      input  enable, answerOBC, a_valid,
      output question, q_valid, pair_valid, pair_question, pair_answer,
             timeout, busy, txn_count
   );

   modport master (
      output enable, answerOBC, a_valid,
      input  question, q_valid, pair_valid, pair_question, pair_answer,
             timeout, busy, txn_count
   );
endinterface

// File: rtl/question_issuer.sv
// question_issuer -- issues LFSR-generated questions to an OBC, waits (bounded)
// for its answer and hands each question/answer pair to a downstream checker.
// Optional build macro QUESTION_ISSUER_REPEAT_EN: when defined, a timed-out
// question is re-issued (LFSR holds); when undefined the LFSR advances on a
// timeout exactly as on a delivered pair.
module question_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 16,      // 2..255
   parameter logic [3:0]  SEED           = 4'b1001,
   parameter int unsigned GAP_CYCLES     = 4        // 1..15
) (
   input  logic              clk,
   input  logic              reset,   // asynchronous, active low
   question_issuer_if.slave  bus
);
   // An all-zero seed would lock the LFSR, so it is forced to 1.
   localparam logic [3:0] LFSR_INIT = (SEED == 4'b0000) ? 4'b0001 : SEED;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_DELIVER, S_GAP
   } state_t;

   state_t     state;
   logic [3:0] lfsr;
   logic [7:0] wait_cnt;
   logic [3:0] gap_cnt;

   logic [3:0] question_r, pair_question_r, pair_answer_r;
   logic       q_valid_r, pair_valid_r, timeout_r, busy_r;
   logic [7:0] txn_count_r;

   function automatic logic [3:0] lfsr_next(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction

   // Transaction FSM; every output is a register set on the edge entering the
   // state in which it must be seen, so strobes line up with their state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         lfsr            <= LFSR_INIT;
         wait_cnt        <= '0;
         gap_cnt         <= '0;
         question_r      <= '0;
         pair_question_r <= '0;
         pair_answer_r   <= '0;
         txn_count_r     <= '0;
         q_valid_r       <= 1'b0;
         pair_valid_r    <= 1'b0;
         timeout_r       <= 1'b0;
         busy_r          <= 1'b0;
      end else begin
         q_valid_r    <= 1'b0;
         pair_valid_r <= 1'b0;
         timeout_r    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.enable) begin
                  state      <= S_ISSUE;
                  question_r <= lfsr;
                  q_valid_r  <= 1'b1;
                  busy_r     <= 1'b1;
               end
            end
            S_ISSUE: begin
               state    <= S_WAIT;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               // An answer in the expiry cycle still counts as delivered.
               if (bus.a_valid) begin
                  state           <= S_DELIVER;
                  pair_valid_r    <= 1'b1;
                  pair_question_r <= question_r;
                  pair_answer_r   <= bus.answerOBC;
                  txn_count_r     <= txn_count_r + 8'd1;
                  lfsr            <= lfsr_next(lfsr);
               end else if (wait_cnt == WAIT_LAST) begin
                  state     <= S_GAP;
                  gap_cnt   <= '0;
                  timeout_r <= 1'b1;
`ifdef QUESTION_ISSUER_REPEAT_EN
                  lfsr      <= lfsr;
`else
                  lfsr      <= lfsr_next(lfsr);
`endif
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DELIVER: begin
               state   <= S_GAP;
               gap_cnt <= '0;
            end
            S_GAP: begin
               // enable is only looked at here, so dropping it never aborts
               // a transaction already in flight.
               if (gap_cnt == GAP_LAST) begin
                  if (bus.enable) begin
                     state      <= S_ISSUE;
                     question_r <= lfsr;
                     q_valid_r  <= 1'b1;
                  end else begin
                     state  <= S_IDLE;
                     busy_r <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.question      = question_r;
   assign bus.q_valid       = q_valid_r;
   assign bus.pair_valid    = pair_valid_r;
   assign bus.pair_question = pair_question_r;
   assign bus.pair_answer   = pair_answer_r;
   assign bus.timeout       = timeout_r;
   assign bus.busy          = busy_r;
   assign bus.txn_count     = txn_count_r;
endmodule

// File: doc/question_issuer.md
QUESTION_ISSUER -- requirements
Module: question_issuer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the max cycles spent in WAIT for an OBC answer; legal range 2..255.
REQ-002 Parameter SEED, default 4'b1001, SHALL set the LFSR reset value; 4'b0000 SHALL be replaced by 4'b0001.
REQ-003 Parameter GAP_CYCLES, default 4, SHALL set the idle cycles between transactions; legal range 1..15.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high = keep issuing questions.
REQ-007 question  out  4  current question to OBC, stable from ISSUE until next ISSUE.
REQ-008 q_valid  out  1  one-cycle strobe, question newly valid.
REQ-009 answerOBC  in  4  OBC answer.
REQ-010 a_valid  in  1  answerOBC valid this cycle.
REQ-011 pair_valid  out  1  one-cycle strobe, pair_question/pair_answer valid for the downstream checker.
REQ-012 pair_question  out  4  question of delivered pair.
REQ-013 pair_answer  out  4  captured answerOBC of delivered pair.
REQ-014 timeout  out  1  one-cycle strobe, no answer within TIMEOUT_CYCLES.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 txn_count  out  8  count of delivered pairs, wraps 255->0.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DELIVER, GAP.
REQ-018 IDLE->ISSUE when enable=1; otherwise stay in IDLE.
REQ-019 ISSUE SHALL last exactly one cycle: question<=LFSR value, q_valid=1; next state WAIT.
REQ-020 a_valid SHALL be sampled only in WAIT; a_valid in any other state is ignored.
REQ-021 WAIT counter starts at 0 on entry; on a_valid, answerOBC is captured and the next state is DELIVER.
REQ-022 If no a_valid and counter==TIMEOUT_CYCLES-1, timeout SHALL pulse on the following cycle and the FSM SHALL enter GAP with no pair delivered.
REQ-023 a_valid in the expiry cycle SHALL win: DELIVER, no timeout.
REQ-024 DELIVER SHALL last one cycle: pair_valid=1, pair_question=question, pair_answer=captured answer, txn_count+1, LFSR advances.
REQ-025 LFSR SHALL be 4-bit Fibonacci, next={q[2:0], q[3]^q[2]}, period 15, never all-zero.
REQ-026 GAP SHALL last GAP_CYCLES cycles, then go to ISSUE if enable=1, else IDLE.
REQ-027 Deasserting enable mid-transaction SHALL NOT abort it; the FSM returns to IDLE after GAP.
REQ-028 pair_question/pair_answer SHALL hold their last values until the next DELIVER.

Reset
REQ-029 While reset=0: state=IDLE, LFSR=SEED (or 4'b0001), question=0, pair_question=0, pair_answer=0, txn_count=0, q_valid=pair_valid=timeout=busy=0.
REQ-030 Reset asserted mid-transaction SHALL drop all strobes immediately; first ISSUE after release SHALL present SEED.

Configuration
REQ-031 Macro QUESTION_ISSUER_REPEAT_EN defined: on timeout the LFSR SHALL NOT advance, so the same question is re-issued.
REQ-032 Macro undefined: on timeout the LFSR SHALL advance exactly as at DELIVER.

Verification
REQ-033 Reset release, enable=1 -> q_valid one cycle later with question=4'b1001; busy=1.
REQ-034 OBC responds answerOBC=4'b1010 with a_valid 3 cycles after q_valid -> pair_valid next cycle, pair_question=4'b1001, pair_answer=4'b1010, txn_count=1; next question after GAP_CYCLES=4'b0011.
REQ-035 No a_valid -> timeout pulses exactly 16 cycles after WAIT entry, no pair_valid; next question 4'b0011 without macro, 4'b1001 with QUESTION_ISSUER_REPEAT_EN.
REQ-036 a_valid in the expiry cycle -> pair_valid=1, timeout stays 0; a_valid during ISSUE or GAP -> no effect.
REQ-037 256 answered transactions -> txn_count wraps to 0; 15 consecutive questions are all distinct and nonzero, the 16th equals the 1st.
REQ-038 reset=0 during WAIT -> all outputs at reset values in the same cycle; enable=0 during WAIT -> transaction completes, then IDLE with busy=0.
